// File: rtl/r2r_dac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : r2r_dac_sequencer
// Purpose  : Sample scheduler for an 8-bit R2R DAC. A programmable divider
//            produces a sample-rate tick. On each tick the DAC code comes from
//            one of three sources: a small streaming FIFO filled by a
//            valid/ready producer, an internal sawtooth generator, or an
//            internal triangle generator. It can also simply hold.
// Ports    : clk         - system clock
//            rst         - synchronous reset, active-high
//            cfg_load    - one-cycle pulse that loads the divider from cfg_data
//            cfg_data    - divider value (tick period = cfg_data + 1 cycles)
//            mode        - 00 hold, 01 stream, 10 sawtooth, 11 triangle
//            s_valid     - producer sample valid
//            s_data      - producer sample
//            s_ready     - FIFO can accept a sample
//            dac_out     - registered code to the R2R ladder bits b0..b7
//            sample_tick - registered, high when dac_out takes a new sample slot
//            underflow   - sticky, set by a stream tick with an empty FIFO
//            uf_count    - saturating underflow event counter
//                          (present only when R2R_DAC_UFCNT_EN is defined)
// Options  : `define R2R_DAC_UFCNT_EN adds the uf_count output and its counter.
// Revision : 1.0 - initial release
// ============================================================================
module r2r_dac_sequencer #(
   parameter int           FIFO_DEPTH = 4,
   parameter int           STEP       = 1,
   parameter logic [7:0]   RESET_CODE = 8'h00
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_load,
   input  logic [7:0]      cfg_data,
   input  logic [1:0]      mode,
   input  logic            s_valid,
   input  logic [7:0]      s_data,
   output logic            s_ready,
   output logic [7:0]      dac_out,
   output logic            sample_tick,
   output logic            underflow
`ifdef R2R_DAC_UFCNT_EN
   ,
   output logic [7:0]      uf_count
`endif
);

   localparam int          c_AW      = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  c_STEP8   = 8'(STEP);
   localparam logic [8:0]  c_STEP9   = 9'(STEP);

   localparam logic [1:0]  c_MODE_HOLD   = 2'b00;
   localparam logic [1:0]  c_MODE_STREAM = 2'b01;
   localparam logic [1:0]  c_MODE_SAW    = 2'b10;
   localparam logic [1:0]  c_MODE_TRI    = 2'b11;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [7:0]       r_div;
   logic [7:0]       r_cnt;
   logic [1:0]       r_mode_q;
   logic [7:0]       r_phase;
   dir_t             r_dir;
   logic [7:0]       r_dac;
   logic             r_tick;
   logic             r_underflow;
   logic [c_AW:0]    r_wptr;
   logic [c_AW:0]    r_rptr;
   logic [7:0]       r_mem [FIFO_DEPTH];
`ifdef R2R_DAC_UFCNT_EN
   logic [7:0]       r_uf_count;
`endif

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic             w_mode_chg;
   logic             w_tick;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_uf_event;
   logic [8:0]       w_sum;
   logic [7:0]       w_phase_nxt;
   dir_t             w_dir_nxt;

   // r_mode_q follows mode even through reset, so leaving reset with a
   // steady mode is not mistaken for a mode change.
   assign w_mode_chg = (mode != r_mode_q);

   // The tick is suppressed in a load cycle and in a mode-change cycle.
   assign w_tick     = (r_cnt == r_div) && !cfg_load && !w_mode_chg;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);

   // Readiness depends only on occupancy, never on a same-cycle pop.
   assign s_ready    = !rst && !w_full;
   assign w_push     = s_valid && s_ready;

   // Emptiness is judged on the current state, so a push in a tick cycle is
   // never bypassed to the output.
   assign w_pop      = w_tick && (mode == c_MODE_STREAM) && !w_empty;
   assign w_uf_event = w_tick && (mode == c_MODE_STREAM) && w_empty;

   assign w_sum      = {1'b0, r_phase} + c_STEP9;

   always_comb begin
      w_phase_nxt = r_phase;
      w_dir_nxt   = r_dir;
      if (mode == c_MODE_SAW) begin
         w_phase_nxt = w_sum[7:0];
      end else if (mode == c_MODE_TRI) begin
         if (r_dir == DIR_UP) begin
            if (w_sum >= 9'd255) begin
               w_phase_nxt = 8'd255;
               w_dir_nxt   = DIR_DOWN;
            end else begin
               w_phase_nxt = w_sum[7:0];
            end
         end else begin
            if (r_phase <= c_STEP8) begin
               w_phase_nxt = 8'd0;
               w_dir_nxt   = DIR_UP;
            end else begin
               w_phase_nxt = r_phase - c_STEP8;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage (no reset needed; validity is tracked by the pointers)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[c_AW-1:0]] <= s_data;
      end
   end

   // ------------------------------------------------------------------------
   // Divider, generators, FIFO pointers and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      r_mode_q <= mode;
      if (rst) begin
         r_div       <= 8'd0;
         r_cnt       <= 8'd0;
         r_phase     <= 8'd0;
         r_dir       <= DIR_UP;
         r_dac       <= RESET_CODE;
         r_tick      <= 1'b0;
         r_underflow <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
`ifdef R2R_DAC_UFCNT_EN
         r_uf_count  <= 8'd0;
`endif
      end else begin
         r_tick <= w_tick;

         // Divider counter
         if (cfg_load) begin
            r_div <= cfg_data;
            r_cnt <= 8'd0;
         end else if (w_mode_chg || w_tick) begin
            r_cnt <= 8'd0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end

         // Generator phase restarts on every mode change
         if (w_mode_chg) begin
            r_phase <= 8'd0;
            r_dir   <= DIR_UP;
         end else if (w_tick) begin
            r_phase <= w_phase_nxt;
            r_dir   <= w_dir_nxt;
         end

         // Output code selection
         if (w_tick) begin
            case (mode)
               c_MODE_HOLD   : r_dac <= r_dac;
               c_MODE_STREAM : if (!w_empty) r_dac <= r_mem[r_rptr[c_AW-1:0]];
               default       : r_dac <= w_phase_nxt;
            endcase
         end

         // Underflow flag and counter; a load cannot coincide with an
         // underflow event because the load suppresses the tick.
         if (cfg_load) begin
            r_underflow <= 1'b0;
         end else if (w_uf_event) begin
            r_underflow <= 1'b1;
         end
`ifdef R2R_DAC_UFCNT_EN
         if (cfg_load) begin
            r_uf_count <= 8'd0;
         end else if (w_uf_event && (r_uf_count != 8'hFF)) begin
            r_uf_count <= r_uf_count + 8'd1;
         end
`endif

         // FIFO pointers
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
      end
   end

   assign dac_out     = r_dac;
   assign sample_tick = r_tick;
   assign underflow   = r_underflow;
`ifdef R2R_DAC_UFCNT_EN
   assign uf_count    = r_uf_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_r2r_dac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_r2r_dac_sequencer
// Purpose  : Directed self-checking bench for r2r_dac_sequencer with
//            hand-computed expected values (default parameters:
//            FIFO_DEPTH=4, STEP=1, RESET_CODE=8'h00).
// Revision : 1.0 - initial release
// ============================================================================
module tb_r2r_dac_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_load;
   logic [7:0] cfg_data;
   logic [1:0] mode;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic [7:0] dac_out;
   logic       sample_tick;
   logic       underflow;
`ifdef R2R_DAC_UFCNT_EN
   logic [7:0] uf_count;
`endif

   int checks = 0;
   int errors = 0;

   r2r_dac_sequencer u_dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_data    (cfg_data),
      .mode        (mode),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .dac_out     (dac_out),
      .sample_tick (sample_tick),
      .underflow   (underflow)
`ifdef R2R_DAC_UFCNT_EN
      ,
      .uf_count    (uf_count)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are changed and outputs sampled 1 ns after
   // the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] exp_stream [4];
      exp_stream[0] = 8'h11;
      exp_stream[1] = 8'h22;
      exp_stream[2] = 8'h33;
      exp_stream[3] = 8'h44;

      // ---------------- Reset state ----------------
      rst = 1'b1; cfg_load = 1'b0; cfg_data = 8'd0; mode = 2'b00;
      s_valid = 1'b0; s_data = 8'd0;
      step(); step();
      chk("rst_dac",       dac_out,     8'h00);
      chk("rst_tick",      sample_tick, 1'b0);
      chk("rst_underflow", underflow,   1'b0);
      chk("rst_ready",     s_ready,     1'b0);
`ifdef R2R_DAC_UFCNT_EN
      chk("rst_ufcnt",     uf_count,    8'd0);
`endif

      // ---------------- Sawtooth, div=3 ----------------
      rst = 1'b0; mode = 2'b10; cfg_load = 1'b1; cfg_data = 8'd3;
      #1;
      chk("ready_after_rst", s_ready, 1'b1);
      step();
      cfg_load = 1'b0;
      for (int n = 1; n <= 256; n++) begin
         repeat (3) step();
         chk("saw_idle", sample_tick, 1'b0);
         step();
         chk("saw_tick", sample_tick, 1'b1);
         chk("saw_val",  dac_out,     n % 256);
      end

      // ---------------- Triangle, div=0 ----------------
      mode = 2'b11; cfg_load = 1'b1; cfg_data = 8'd0;
      step();
      cfg_load = 1'b0;
      chk("tri_chg_tick", sample_tick, 1'b0);
      chk("tri_chg_hold", dac_out,     8'd0);
      for (int k = 1; k <= 255; k++) begin
         step();
         chk("tri_up", dac_out, k);
      end
      for (int k = 254; k >= 0; k--) begin
         step();
         chk("tri_down", dac_out, k);
      end
      step();
      chk("tri_reup", dac_out, 8'd1);
      chk("tri_reup_tick", sample_tick, 1'b1);

      // ---------------- Stream, div=7, fill FIFO ----------------
      mode = 2'b01; cfg_load = 1'b1; cfg_data = 8'd7;
      step();
      cfg_load = 1'b0;
      s_valid = 1'b1; s_data = 8'h11; step();
      s_data = 8'h22; step();
      s_data = 8'h33; step();
      chk("ready_before_full", s_ready, 1'b1);
      s_data = 8'h44; step();
      s_valid = 1'b0;
      chk("ready_full", s_ready, 1'b0);
      repeat (3) step();
      chk("ready_full_held", s_ready, 1'b0);
      chk("stream_no_tick",  sample_tick, 1'b0);
      step();
      chk("stream_tick0",  sample_tick, 1'b1);
      chk("stream_val0",   dac_out,     8'h11);
      chk("ready_after_pop", s_ready,   1'b1);
      chk("stream_no_uf",  underflow,   1'b0);
      for (int i = 1; i < 4; i++) begin
         repeat (8) step();
         chk("stream_tick", sample_tick, 1'b1);
         chk("stream_val",  dac_out,     exp_stream[i]);
      end

      // ---------------- Underflow, div=2 ----------------
      cfg_load = 1'b1; cfg_data = 8'd2;
      step();
      cfg_load = 1'b0;
      step();
      chk("uf_before", underflow, 1'b0);
      step(); step();
      chk("uf_set",      underflow,   1'b1);
      chk("uf_dac_hold", dac_out,     8'h44);
      chk("uf_tick",     sample_tick, 1'b1);
      repeat (3) step();
      chk("uf_sticky",   underflow,   1'b1);
`ifdef R2R_DAC_UFCNT_EN
      chk("ufcnt_two",   uf_count,    8'd2);
`endif
      cfg_load = 1'b1;
      step();
      cfg_load = 1'b0;
      chk("uf_cleared", underflow, 1'b0);
`ifdef R2R_DAC_UFCNT_EN
      chk("ufcnt_cleared", uf_count, 8'd0);
      repeat (900) step();
      chk("ufcnt_sat", uf_count,  8'd255);
      chk("uf_sat_flag", underflow, 1'b1);
`endif

      // ---------------- Push in a tick cycle with empty FIFO ----------------
      cfg_load = 1'b1; cfg_data = 8'd2;
      step();
      cfg_load = 1'b0;
      chk("push_tick_clr", underflow, 1'b0);
      step(); step();
      s_valid = 1'b1; s_data = 8'h5A;
      step();
      s_valid = 1'b0;
      chk("push_tick_uf",    underflow, 1'b1);
      chk("push_tick_hold",  dac_out,   8'h44);
      chk("push_tick_ready", s_ready,   1'b1);
      repeat (3) step();
      chk("push_tick_val",  dac_out,     8'h5A);
      chk("push_tick_tick", sample_tick, 1'b1);

      // ---------------- Reset mid-sawtooth with 2 FIFO entries ----------------
      mode = 2'b10; cfg_load = 1'b1; cfg_data = 8'd0;
      step();
      cfg_load = 1'b0;
      s_valid = 1'b1; s_data = 8'hAA; step();
      s_data = 8'hBB; step();
      s_valid = 1'b0;
      repeat (62) step();
      chk("saw_at_40", dac_out, 8'h40);
      rst = 1'b1;
      step();
      chk("midrst_dac",   dac_out,     8'h00);
      chk("midrst_tick",  sample_tick, 1'b0);
      chk("midrst_ready", s_ready,     1'b0);
      chk("midrst_uf",    underflow,   1'b0);
      rst = 1'b0; mode = 2'b01;
      #1;
      chk("postrst_ready", s_ready, 1'b1);
      step();
      chk("postrst_chg_uf",  underflow, 1'b0);
      chk("postrst_chg_dac", dac_out,   8'h00);
      step();
      chk("postrst_empty_uf",   underflow,   1'b1);
      chk("postrst_empty_dac",  dac_out,     8'h00);
      chk("postrst_empty_tick", sample_tick, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/r2r_dac_sequencer.md
Name: r2r_dac_sequencer

Overview:
- Sample scheduler that feeds the 8-bit R2R DAC input bus on a programmable sample-rate tick.
- Chooses the sample source each tick: a small streaming FIFO fed by an external valid/ready producer, or an internal sawtooth/triangle generator.
- Replaces the free-running divider/ext_data path in front of the R2R ladder. Digital domain only (VDPWR).

Parameters:
- FIFO_DEPTH, 4, stream FIFO entries; power of two, ≥2.
- STEP, 1, generator phase increment per tick; 1..127.
- RESET_CODE, 8'h00, dac_out value after reset.

Ports:
- clk  in  1  system clock (10 MHz nominal).
- rst  in  1  synchronous reset, active-high.
- cfg_load  in  1  single-cycle pulse; loads divider from cfg_data.
- cfg_data  in  8  divider value.
- mode  in  2  00 hold, 01 stream, 10 sawtooth, 11 triangle.
- s_valid  in  1  producer sample valid.
- s_data  in  8  producer sample.
- s_ready  out  1  FIFO can accept.
- dac_out  out  8  registered code to the R2R ladder bits b0..b7.
- sample_tick  out  1  registered; high in the cycle dac_out takes a new sample slot.
- underflow  out  1  sticky; stream tick with an empty FIFO.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - dac_out=RESET_CODE; sample_tick=0; underflow=0.
  - div=0; cnt=0; FIFO empty; phase=0; dir=up.
  - s_ready=0 while rst is high; 1 on the first cycle after.
- Divider:
  - Internal tick_i=(cnt==div). On tick_i, cnt←0; otherwise cnt←cnt+1.
  - Tick period is div+1 cycles; div=0 gives a tick every cycle.
- cfg_load:
  - Sets div←cfg_data, cnt←0 and clears underflow.
  - tick_i is suppressed in the load cycle, so the first tick comes div+1 cycles later.
- Latency: sample_tick and dac_out both update on the edge after tick_i, i.e. one-cycle latency from tick_i.
- FIFO:
  - Push when s_valid & s_ready. s_ready = !full, independent of any same-cycle pop.
  - Full FIFO with a pop in that cycle: s_ready stays 0, no push.
  - Empty FIFO with a push and a stream tick in the same cycle: no bypass. The tick counts as an underflow and the pushed sample is stored.
  - Contents are preserved across mode changes. Data order is strict FIFO.
- On each tick_i, by mode:
  - hold: dac_out unchanged; sample_tick still pulses.
  - stream, FIFO not empty: pop; dac_out←head.
  - stream, FIFO empty: dac_out holds its last value; underflow←1.
  - sawtooth: phase←(phase+STEP) mod 256; dac_out←new phase.
  - triangle, dir up: if phase+STEP≥255, phase←255 and dir←down; else phase←phase+STEP.
  - triangle, dir down: if phase≤STEP, phase←0 and dir←up; else phase←phase−STEP.
  - triangle: dac_out←new phase.
- Mode change (mode differs from the previous cycle's mode):
  - cnt←0; phase←0; dir←up.
  - No tick in that cycle. dac_out holds until the next tick.
- Reset mid-stream: FIFO is discarded, underflow is cleared, and the producer sees s_ready=0 for the reset cycle.

Optional Feature:
- Macro: R2R_DAC_UFCNT_EN.
- Defined: adds output uf_count[7:0].
  - Increments on every underflow event and saturates at 255.
  - Cleared by rst and by cfg_load.
- Undefined: no port and no counter. The underflow flag alone reports underflow.

Test Plan:
- Reset, cfg_load with cfg_data=3, mode=10 (STEP=1) → sample_tick every 4 cycles; dac_out reads 1,2,3,… and wraps 255→0 on the 256th tick.
- mode=11, div=0 → dac_out climbs 1..255; next tick gives 254 with dir down; it reaches 0, then climbs to 1.
- mode=01, div=7; push 0x11, 0x22, 0x33, 0x44 → s_ready drops after the 4th push. Ticks output 0x11, 0x22, 0x33, 0x44 in order. s_ready returns 1 the cycle after the first pop.
- Stream with an empty FIFO, div=2 → underflow=1 on the first tick, dac_out holds its prior value, flag stays set. cfg_load clears it. With R2R_DAC_UFCNT_EN, 300 underflow ticks → uf_count=255.
- Push 0x5A exactly in a tick cycle with an empty FIFO → underflow set; 0x5A appears on the following tick.
- Assert rst mid-sawtooth at dac_out=0x40 with 2 FIFO entries held → next cycle dac_out=RESET_CODE, FIFO empty, sample_tick=0, s_ready=0 during reset then 1.
